// File: rtl/noc_ni_pkg.sv
// Shared flit format definitions for the NoC network interface.
// Type codes, field widths and TX/RX tracker state encodings.
package noc_ni_pkg;

   localparam int NI_DATA_WIDTH = 32;
   localparam int LEN_W         = 12;
   localparam int ADDR_W        = 4;
   localparam int ID_W          = 8;
   localparam int TYPE_W        = 3;

   typedef enum logic [TYPE_W-1:0] {
      FT_HEAD = 3'b001,
      FT_BODY = 3'b010,
      FT_TAIL = 3'b100
   } flit_type_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEAD,
      S_BODY
   } tx_state_e;

   typedef enum logic {
      R_IDLE,
      R_PKT
   } rx_state_e;

endpackage

// File: rtl/noc_ni_rx_fifo.sv
// Ejection FIFO: count-based, one-cycle write, combinational head read.
// Drops writes when full (unless popping); o_space is registered (>=2 free).
module noc_ni_rx_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_dat,
   output logic         o_empty,
   output logic         o_space,
   output logic         o_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_LIM  = CW'(DEPTH - 2);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          r_space;
   logic          r_ovf;

   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic [CW-1:0] w_cnt_nxt;

   assign w_full  = (r_cnt == CNT_FULL);
   assign o_empty = (r_cnt == '0);
   assign w_pop   = i_pop & ~o_empty;
   // A pop frees the slot in the same cycle, so a write at full still lands.
   assign w_push  = i_push & (~w_full | w_pop);

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + 1'b1;
         2'b01:   w_cnt_nxt = r_cnt - 1'b1;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_space <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         r_cnt   <= w_cnt_nxt;
         r_space <= (w_cnt_nxt <= CNT_LIM);
         if (i_push && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_dat;
   end

   assign o_dat   = r_mem[r_rd];
   assign o_space = r_space;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/noc_ni.sv
// NoC network interface: packetizes requests into flits towards the router and
// buffers ejected flits, tracking RX packet framing and flagging errors.
module noc_ni
   import noc_ni_pkg::*;
#(
   parameter int          DATA_WIDTH = NI_DATA_WIDTH,
   parameter logic [3:0]  CUR_ADDR   = 4'b0010,
   parameter int          RX_DEPTH   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_pkt_valid,
   output logic                  o_pkt_ready,
   input  logic [ADDR_W-1:0]     i_pkt_dst,
   input  logic [LEN_W-1:0]      i_pkt_len,
   input  logic                  i_pld_valid,
   output logic                  o_pld_ready,
   input  logic [DATA_WIDTH-5:0] i_pld_data,
   output logic [DATA_WIDTH-1:0] o_tx,
   output logic                  o_drts,
   input  logic                  i_cts,
   input  logic [DATA_WIDTH-1:0] i_rx,
   input  logic                  i_rts,
   output logic                  o_dcts,
   output logic                  o_ej_valid,
   input  logic                  i_ej_ready,
   output logic [DATA_WIDTH-1:0] o_ej_flit,
   output logic                  o_ej_perr,
   output logic                  o_tx_err,
   output logic                  o_rx_ovf,
   output logic                  o_rx_proto_err
);

   tx_state_e              r_state;
   rx_state_e              r_rx_state;
   logic [LEN_W-1:0]       r_len;
   logic [LEN_W-1:0]       r_rem;
   logic [ADDR_W-1:0]      r_dst;
   logic [ID_W-1:0]        r_id;
   logic                   r_tx_err;
   logic                   r_proto_err;

   logic                   w_len_ok;
   logic                   w_drts;
   logic [TYPE_W-1:0]      w_type;
   logic [DATA_WIDTH-5:0]  w_fields;
   logic                   w_empty;
   logic [TYPE_W-1:0]      w_rx_type;

   assign w_len_ok = (r_len >= LEN_W'(2));

   always_comb begin
      w_drts = 1'b0;
      case (r_state)
         S_HEAD:  w_drts = i_cts & w_len_ok;
         S_BODY:  w_drts = i_cts & i_pld_valid;
         default: w_drts = 1'b0;
      endcase
   end

   // Reset gating keeps the router side quiet during the reset cycle itself.
   assign o_drts      = w_drts & ~i_rst;
   assign o_pld_ready = (r_state == S_BODY) & i_cts & ~i_rst;
   assign o_pkt_ready = (r_state == S_IDLE) & i_pkt_valid & ~i_rst;

   always_comb begin
      w_type   = FT_BODY;
      w_fields = i_pld_data;
      if (r_state == S_HEAD) begin
         w_type   = FT_HEAD;
         w_fields = {r_len, r_dst, CUR_ADDR, r_id};
      end else if (r_rem == LEN_W'(1)) begin
         w_type   = FT_TAIL;
      end
   end

   assign o_tx = {w_type, w_fields, ^{w_type, w_fields}};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_len    <= '0;
         r_rem    <= '0;
         r_dst    <= '0;
         r_id     <= '0;
         r_tx_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_pkt_valid) begin
                  r_len   <= i_pkt_len;
                  r_dst   <= i_pkt_dst;
                  r_state <= S_HEAD;
               end
            end
            S_HEAD: begin
               if (!w_len_ok) begin
                  r_tx_err <= 1'b1;
                  r_state  <= S_IDLE;
               end else if (i_cts) begin
                  r_rem   <= r_len - LEN_W'(1);
                  r_state <= S_BODY;
               end
            end
            S_BODY: begin
               if (w_drts) begin
                  if (r_rem == LEN_W'(1)) begin
                     r_id    <= r_id + 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_rem <= r_rem - LEN_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_rx_type = i_rx[DATA_WIDTH-1 -: TYPE_W];

   // Tracker follows every flit on the link, including ones the FIFO drops.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_state  <= R_IDLE;
         r_proto_err <= 1'b0;
      end else if (i_rts) begin
         case (w_rx_type)
            FT_HEAD: begin
               if (r_rx_state == R_PKT) r_proto_err <= 1'b1;
               r_rx_state <= R_PKT;
            end
            FT_BODY: begin
               if (r_rx_state == R_IDLE) r_proto_err <= 1'b1;
               r_rx_state <= R_PKT;
            end
            FT_TAIL: begin
               if (r_rx_state == R_IDLE) r_proto_err <= 1'b1;
               r_rx_state <= R_IDLE;
            end
            default: r_rx_state <= r_rx_state;
         endcase
      end
   end

   noc_ni_rx_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_rts),
      .i_dat   (i_rx),
      .i_pop   (i_ej_ready),
      .o_dat   (o_ej_flit),
      .o_empty (w_empty),
      .o_space (o_dcts),
      .o_ovf   (o_rx_ovf)
   );

   assign o_ej_valid     = ~w_empty;
   assign o_ej_perr      = ^o_ej_flit;
   assign o_tx_err       = r_tx_err;
   assign o_rx_proto_err = r_proto_err;

endmodule

// File: tb/tb_noc_ni.sv
// Randomized bench for noc_ni against a transaction-level model of the
// packetizer (flit index within packet) and the ejection queue.
module tb_noc_ni;

   logic        clk = 1'b0;
   logic        rst;
   logic        pkt_valid, pkt_ready;
   logic [3:0]  pkt_dst;
   logic [11:0] pkt_len;
   logic        pld_valid, pld_ready;
   logic [27:0] pld_data;
   logic [31:0] tx;
   logic        drts, cts;
   logic [31:0] rx;
   logic        rts, dcts;
   logic        ej_valid, ej_ready;
   logic [31:0] ej_flit;
   logic        ej_perr, tx_err, rx_ovf, rx_proto_err;

   always #5 clk = ~clk;

   noc_ni #(.DATA_WIDTH(32), .CUR_ADDR(4'b0010), .RX_DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_pkt_valid(pkt_valid), .o_pkt_ready(pkt_ready),
      .i_pkt_dst(pkt_dst), .i_pkt_len(pkt_len),
      .i_pld_valid(pld_valid), .o_pld_ready(pld_ready), .i_pld_data(pld_data),
      .o_tx(tx), .o_drts(drts), .i_cts(cts),
      .i_rx(rx), .i_rts(rts), .o_dcts(dcts),
      .o_ej_valid(ej_valid), .i_ej_ready(ej_ready),
      .o_ej_flit(ej_flit), .o_ej_perr(ej_perr),
      .o_tx_err(tx_err), .o_rx_ovf(rx_ovf), .o_rx_proto_err(rx_proto_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   // Model state
   bit          m_act;
   logic [11:0] m_len;
   logic [3:0]  m_dst;
   int          m_sent;
   int          m_id;
   bit          m_txerr;
   logic [31:0] m_q[$];
   bit          m_ovf, m_proto, m_inpkt, m_dcts;
   logic [31:0] tx_log[$];

   function automatic logic [31:0] flit(input logic [2:0] t, input logic [27:0] f);
      return {t, f, ^{t, f}};
   endfunction

   task automatic model_reset();
      m_act = 0; m_len = 0; m_dst = 0; m_sent = 0; m_id = 0; m_txerr = 0;
      m_q.delete(); m_ovf = 0; m_proto = 0; m_inpkt = 0; m_dcts = 0;
   endtask

   task automatic step();
      bit e_pkr, e_drts, e_pldr, full, pop;
      logic [31:0] e_tx;
      logic [2:0]  t;
      @(negedge clk);
      if (drts) tx_log.push_back(tx);
      if (rst) begin
         chk("rst_drts", drts, 0);
         chk("rst_pkt_ready", pkt_ready, 0);
         chk("rst_pld_ready", pld_ready, 0);
         model_reset();
      end else begin
         e_pkr  = !m_act && pkt_valid;
         e_drts = m_act && m_len >= 2 && cts && (m_sent == 0 || pld_valid);
         e_pldr = m_act && m_sent > 0 && cts;
         chk("pkt_ready", pkt_ready, e_pkr);
         chk("drts", drts, e_drts);
         chk("pld_ready", pld_ready, e_pldr);
         if (e_drts) begin
            if (m_sent == 0)
               e_tx = flit(3'b001, {m_len, m_dst, 4'b0010, 8'(m_id)});
            else if (m_sent == int'(m_len) - 1)
               e_tx = flit(3'b100, pld_data);
            else
               e_tx = flit(3'b010, pld_data);
            chk("tx", tx, e_tx);
         end
         chk("dcts", dcts, m_dcts);
         chk("ej_valid", ej_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("ej_flit", ej_flit, m_q[0]);
            chk("ej_perr", ej_perr, ^m_q[0]);
         end
         chk("tx_err", tx_err, m_txerr);
         chk("rx_ovf", rx_ovf, m_ovf);
         chk("rx_proto_err", rx_proto_err, m_proto);

         if (e_pkr) begin
            m_act = 1; m_len = pkt_len; m_dst = pkt_dst; m_sent = 0;
         end else if (m_act) begin
            if (m_len < 2) begin
               m_act = 0; m_txerr = 1;
            end else if (e_drts) begin
               m_sent++;
               if (m_sent == int'(m_len)) begin
                  m_act = 0; m_id = (m_id + 1) % 256;
               end
            end
         end

         full = (m_q.size() == 4);
         pop  = (m_q.size() > 0) && ej_ready;
         if (pop) void'(m_q.pop_front());
         if (rts) begin
            if (full && !pop) m_ovf = 1;
            else m_q.push_back(rx);
            t = rx[31:29];
            if (t == 3'b001) begin
               if (m_inpkt) m_proto = 1;
               m_inpkt = 1;
            end else if (t == 3'b010) begin
               if (!m_inpkt) m_proto = 1;
               m_inpkt = 1;
            end else if (t == 3'b100) begin
               if (!m_inpkt) m_proto = 1;
               m_inpkt = 0;
            end
         end
         m_dcts = (4 - m_q.size()) >= 2;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_rx();
      logic [2:0]  t;
      logic [31:0] f;
      case ($urandom_range(0, 7))
         0, 1, 2: t = 3'b010;
         3, 4:    t = 3'b001;
         5, 6:    t = 3'b100;
         default: t = 3'b011;
      endcase
      f = flit(t, 28'($urandom));
      if ($urandom_range(0, 7) == 0) f[0] = ~f[0];
      return f;
   endfunction

   int tails;

   initial begin
      rst = 1; pkt_valid = 0; pkt_dst = 0; pkt_len = 0; pld_valid = 0;
      pld_data = 0; cts = 0; rx = 0; rts = 0; ej_ready = 0;
      model_reset();
      repeat (3) step();
      rst = 0;
      step();
      step();
      chk("dcts_after_rst", dcts, 1);

      // Basic 3-flit packet, back to back
      tx_log.delete();
      cts = 1; pld_valid = 1; pld_data = 28'h1;
      pkt_valid = 1; pkt_dst = 4'h1; pkt_len = 12'd3;
      step();
      pkt_valid = 0;
      step();
      step();
      pld_data = 28'h2;
      step();
      step();
      chk("p1_nflits", tx_log.size(), 3);
      if (tx_log.size() == 3) begin
         chk("p1_head", tx_log[0], 32'h2006_2401);
         chk("p1_body", tx_log[1], 32'h4000_0002);
         chk("p1_tail", tx_log[2], 32'h8000_0004);
      end

      // Same packet with a 3-cycle CTS stall mid-body
      tx_log.delete();
      pld_data = 28'h1; pkt_valid = 1;
      step();
      pkt_valid = 0;
      step();
      cts = 0;
      repeat (3) step();
      cts = 1;
      step();
      pld_data = 28'h2;
      step();
      step();
      chk("p2_nflits", tx_log.size(), 3);
      if (tx_log.size() == 3) begin
         chk("p2_head", tx_log[0], 32'h2006_2402);
         chk("p2_body", tx_log[1], 32'h4000_0002);
         chk("p2_tail", tx_log[2], 32'h8000_0004);
      end

      // Too-short packet
      tx_log.delete();
      pkt_valid = 1; pkt_len = 12'd1;
      step();
      pkt_valid = 0;
      repeat (3) step();
      chk("short_nflits", tx_log.size(), 0);
      chk("short_tx_err", tx_err, 1);
      cts = 0; pld_valid = 0;

      // Bad-parity tail in R_IDLE, then fill past capacity
      ej_ready = 0; rts = 1;
      rx = flit(3'b100, 28'h55) ^ 32'h1;
      step();
      for (int i = 0; i < 4; i++) begin
         rx = flit(3'b010, 28'(i + 16));
         step();
      end
      rts = 0;
      step();
      chk("fill_perr", ej_perr, 1);
      chk("fill_proto", rx_proto_err, 1);
      chk("fill_ovf", rx_ovf, 1);
      chk("fill_dcts", dcts, 0);
      ej_ready = 1;
      repeat (5) step();
      ej_ready = 0;

      // Reset in the middle of a body
      tx_log.delete();
      cts = 1; pld_valid = 1; pld_data = 28'h7;
      pkt_valid = 1; pkt_len = 12'd5; pkt_dst = 4'h3;
      step();
      pkt_valid = 0;
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      chk("rst_mid_drts", drts, 0);
      step();
      step();
      tails = 0;
      foreach (tx_log[i]) if (tx_log[i][31:29] == 3'b100) tails++;
      chk("rst_mid_tails", tails, 0);
      chk("rst_mid_nflits", tx_log.size(), 2);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 599) == 0);
         pkt_valid = ($urandom_range(0, 3) == 0);
         pkt_dst   = 4'($urandom);
         pkt_len   = 12'($urandom_range(0, 7));
         pld_valid = ($urandom_range(0, 3) != 0);
         pld_data  = 28'($urandom);
         cts       = ($urandom_range(0, 4) != 0);
         rts       = ($urandom_range(0, 2) != 0);
         rx        = rand_rx();
         ej_ready  = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
